// File: rtl/axis_fifo_pkg.sv
// Word-layout constants shared by the write-side packer, the dual-clock FIFO
// and the read-side unpacker. All positions are functions of IN_W and RATIO.
package axis_fifo_pkg;

   // Data lanes occupy the low RATIO*IN_W bits, lane 0 at the bottom.
   function automatic int data_msb(input int in_w, input int ratio);
      return ratio * in_w - 1;
   endfunction

   function automatic int mask_lsb(input int in_w, input int ratio);
      return ratio * in_w;
   endfunction

   function automatic int mask_msb(input int in_w, input int ratio);
      return ratio * in_w + ratio - 1;
   endfunction

   function automatic int last_bit(input int in_w, input int ratio);
      return ratio * in_w + ratio;
   endfunction

   function automatic int fifo_dsize(input int in_w, input int ratio);
      return ratio * in_w + ratio + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage : axis_fifo_pkg

// File: rtl/axis_fifo_wr_packer.sv
// AXI-Stream slave that packs RATIO narrow beats into one tagged FIFO word
// and pushes it into the write port of the dual-clock FIFO.
module axis_fifo_wr_packer
   import axis_fifo_pkg::*;
#(
   parameter  int IN_W  = 8,
   parameter  int RATIO = 4,
   parameter  int CNT_W = 16,
   localparam int DSIZE = fifo_dsize(IN_W, RATIO)
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic [DSIZE-1:0] fifo_wdata,
   output logic             fifo_winc,
   input  logic             fifo_wfull,
   output logic [CNT_W-1:0] pkt_cnt
);

   localparam int LIDX_W = $clog2(RATIO);
   localparam int DATA_W = data_msb(IN_W, RATIO) + 1;
   localparam int LAST_B = last_bit(IN_W, RATIO);
   localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(RATIO - 1);

   if (!is_pow2(RATIO) || RATIO < 2) begin : g_bad_ratio
      $error("RATIO must be a power of two and at least 2");
   end

   // Accumulator for the word being assembled
   logic [DATA_W-1:0] data_q, data_d;
   logic [RATIO-1:0]  mask_q, mask_d;
   logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;

   // Single-entry output register facing the FIFO write port
   logic [DSIZE-1:0]  out_word_q, out_word_d;
   logic              out_vld_q, out_vld_d;

   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic              accept;
   logic              drain;
   logic              complete;
   logic [DATA_W-1:0] data_ins;
   logic [RATIO-1:0]  mask_ins;

   // The output slot frees up in the same cycle it drains, so a completing
   // beat can refill it without a bubble; tready never looks at tvalid.
   assign drain         = out_vld_q && !fifo_wfull;
   assign s_axis_tready = !out_vld_q || !fifo_wfull;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign complete      = accept && ((lane_idx_q == LAST_LANE) || s_axis_tlast);

   always_comb begin
      data_ins = data_q;
      mask_ins = mask_q;
      for (int i = 0; i < RATIO; i++) begin
         if (lane_idx_q == LIDX_W'(i)) begin
            data_ins[i*IN_W +: IN_W] = s_axis_tdata;
            mask_ins[i]              = 1'b1;
         end
      end
   end

   always_comb begin
      data_d     = data_q;
      mask_d     = mask_q;
      lane_idx_d = lane_idx_q;
      if (complete) begin
         data_d     = '0;
         mask_d     = '0;
         lane_idx_d = '0;
      end else if (accept) begin
         data_d     = data_ins;
         mask_d     = mask_ins;
         lane_idx_d = lane_idx_q + 1'b1;
      end
   end

   always_comb begin
      out_word_d = out_word_q;
      out_vld_d  = out_vld_q;
      if (complete) begin
         out_word_d = {s_axis_tlast, mask_ins, data_ins};
         out_vld_d  = 1'b1;
      end else if (drain) begin
         out_vld_d  = 1'b0;
      end
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (drain && out_word_q[LAST_B]) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         data_q     <= '0;
         mask_q     <= '0;
         lane_idx_q <= '0;
         out_word_q <= '0;
         out_vld_q  <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         data_q     <= data_d;
         mask_q     <= mask_d;
         lane_idx_q <= lane_idx_d;
         out_word_q <= out_word_d;
         out_vld_q  <= out_vld_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign fifo_winc  = out_vld_q;
   assign fifo_wdata = out_word_q;
   assign pkt_cnt    = pkt_cnt_q;

endmodule : axis_fifo_wr_packer

// File: tb/tb_axis_fifo_wr_packer.sv
// Bench for axis_fifo_wr_packer: directed packets against a queue-based
// model of the packing rules, plus literal word/counter expectations.
module tb_axis_fifo_wr_packer;

   localparam int IN_W  = 8;
   localparam int RATIO = 4;
   localparam int CNT_W = 16;
   localparam int DSIZE = RATIO * IN_W + RATIO + 1;

   logic             wclk;
   logic             wrst_n;
   logic [IN_W-1:0]  s_axis_tdata;
   logic             s_axis_tvalid;
   logic             s_axis_tlast;
   logic             s_axis_tready;
   logic [DSIZE-1:0] fifo_wdata;
   logic             fifo_winc;
   logic             fifo_wfull;
   logic [CNT_W-1:0] pkt_cnt;

   axis_fifo_wr_packer #(
      .IN_W  (IN_W),
      .RATIO (RATIO),
      .CNT_W (CNT_W)
   ) dut (
      .wclk          (wclk),
      .wrst_n        (wrst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .fifo_wdata    (fifo_wdata),
      .fifo_winc     (fifo_winc),
      .fifo_wfull    (fifo_wfull),
      .pkt_cnt       (pkt_cnt)
   );

   // ---------------- clock ----------------
   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   logic [DSIZE-1:0] exp_q[$];    // words committed to the output slot, not yet written
   logic [IN_W-1:0]  beat_q[$];   // beats of the word being assembled
   int               model_cnt;
   logic [DSIZE-1:0] dut_log[$];  // every word the FIFO actually accepted
   logic             exp_tready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DSIZE-1:0] pack_word(input logic last);
      logic [DSIZE-1:0] w;
      w = '0;
      for (int i = 0; i < beat_q.size(); i++) begin
         w[i*IN_W +: IN_W]     = beat_q[i];
         w[RATIO*IN_W + i]     = 1'b1;
      end
      w[DSIZE-1] = last;
      return w;
   endfunction

   // Compare on the falling edge, then advance the model with the inputs
   // that the next rising edge will see.
   always @(negedge wclk) begin
      if (!wrst_n) begin
         chk("rst_winc", 64'(fifo_winc), 64'd0);
         chk("rst_wdata", 64'(fifo_wdata), 64'd0);
         chk("rst_tready", 64'(s_axis_tready), 64'd1);
         chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
         exp_q.delete();
         beat_q.delete();
         model_cnt = 0;
      end else begin
         exp_tready = (exp_q.size() == 0) || !fifo_wfull;
         chk("tready", 64'(s_axis_tready), 64'(exp_tready));
         chk("winc", 64'(fifo_winc), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) chk("wdata", 64'(fifo_wdata), 64'(exp_q[0]));
         chk("pkt_cnt", 64'(pkt_cnt), 64'(model_cnt));
         if (fifo_winc && !fifo_wfull) dut_log.push_back(fifo_wdata);
         if (exp_q.size() != 0 && !fifo_wfull) begin
            if (exp_q[0][DSIZE-1]) model_cnt = (model_cnt + 1) % (1 << CNT_W);
            void'(exp_q.pop_front());
         end
         if (s_axis_tvalid && exp_tready) begin
            beat_q.push_back(s_axis_tdata);
            if (beat_q.size() == RATIO || s_axis_tlast) begin
               exp_q.push_back(pack_word(s_axis_tlast));
               beat_q.delete();
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
      bit acc;
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      do begin
         @(negedge wclk);
         acc = s_axis_tready;
         @(posedge wclk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(posedge wclk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   int base;

   initial begin
      wrst_n        = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      fifo_wfull    = 1'b0;
      model_cnt     = 0;
      repeat (3) @(posedge wclk);
      #1 wrst_n = 1'b1;

      // Full 4-beat packet
      base = dut_log.size();
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      send_beat(8'h44, 1'b1);
      idle(3);
      chk("t1_nwr", 64'(dut_log.size() - base), 64'd1);
      chk("t1_word", 64'(dut_log[base]), 64'h1F44332211);
      chk("t1_cnt", 64'(pkt_cnt), 64'd1);

      // 6-beat packet spanning two words
      base = dut_log.size();
      for (int i = 1; i <= 6; i++) send_beat(8'(i), i == 6);
      idle(3);
      chk("t2_nwr", 64'(dut_log.size() - base), 64'd2);
      chk("t2_word0", 64'(dut_log[base]), 64'h0F04030201);
      chk("t2_word1", 64'(dut_log[base+1]), 64'h1300000605);
      chk("t2_cnt", 64'(pkt_cnt), 64'd2);

      // Backpressure: FIFO full while streaming 8 beats
      base = dut_log.size();
      fifo_wfull = 1'b1;
      fork
         begin
            for (int i = 1; i <= 8; i++) send_beat(8'hA0 + 8'(i), i == 8);
         end
         begin
            repeat (12) @(posedge wclk);
            @(negedge wclk);
            chk("t3_stall_wdata", 64'(fifo_wdata), 64'h0FA4A3A2A1);
            chk("t3_stall_tready", 64'(s_axis_tready), 64'd0);
            chk("t3_stall_winc", 64'(fifo_winc), 64'd1);
            @(posedge wclk);
            #1 fifo_wfull = 1'b0;
         end
      join
      idle(4);
      chk("t3_nwr", 64'(dut_log.size() - base), 64'd2);
      chk("t3_word0", 64'(dut_log[base]), 64'h0FA4A3A2A1);
      chk("t3_word1", 64'(dut_log[base+1]), 64'h1FA8A7A6A5);
      chk("t3_cnt", 64'(pkt_cnt), 64'd3);

      // 16 beats back-to-back without tlast
      base = dut_log.size();
      for (int i = 0; i < 16; i++) send_beat(8'h10 + 8'(i), 1'b0);
      idle(3);
      chk("t4_nwr", 64'(dut_log.size() - base), 64'd4);
      chk("t4_word0", 64'(dut_log[base]), 64'h0F13121110);
      chk("t4_word1", 64'(dut_log[base+1]), 64'h0F17161514);
      chk("t4_word2", 64'(dut_log[base+2]), 64'h0F1B1A1918);
      chk("t4_word3", 64'(dut_log[base+3]), 64'h0F1F1E1D1C);
      chk("t4_cnt", 64'(pkt_cnt), 64'd3);

      // Reset after two beats of a word
      base = dut_log.size();
      send_beat(8'h55, 1'b0);
      send_beat(8'h66, 1'b0);
      s_axis_tvalid = 1'b0;
      wrst_n        = 1'b0;
      repeat (2) @(posedge wclk);
      #1 wrst_n = 1'b1;
      chk("t5_nwr_rst", 64'(dut_log.size() - base), 64'd0);
      send_beat(8'h71, 1'b0);
      send_beat(8'h72, 1'b0);
      send_beat(8'h73, 1'b0);
      send_beat(8'h74, 1'b1);
      idle(3);
      chk("t5_nwr", 64'(dut_log.size() - base), 64'd1);
      chk("t5_word", 64'(dut_log[base]), 64'h1F74737271);
      chk("t5_cnt", 64'(pkt_cnt), 64'd1);

      // Single-beat packet
      base = dut_log.size();
      send_beat(8'hAB, 1'b1);
      idle(3);
      chk("t6_nwr", 64'(dut_log.size() - base), 64'd1);
      chk("t6_word", 64'(dut_log[base]), 64'h11000000AB);
      chk("t6_cnt", 64'(pkt_cnt), 64'd2);

      // Drive the counter to its top value, then across the wrap
      for (int i = 0; i < 65533; i++) send_beat(8'(i), 1'b1);
      idle(3);
      chk("t7_cnt_max", 64'(pkt_cnt), 64'hFFFF);
      send_beat(8'hCD, 1'b1);
      idle(3);
      chk("t7_cnt_wrap", 64'(pkt_cnt), 64'h0000);
      chk("t7_wrap_word", 64'(dut_log[dut_log.size()-1]), 64'h11000000CD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_axis_fifo_wr_packer

// File: doc/axis_fifo_wr_packer.md
Name: axis_fifo_wr_packer

Overview:
AXI-Stream slave front end in the write-clock domain, directly upstream of the dual-clock FIFO write port.
- Packs RATIO narrow input beats into one wide FIFO word, tagged with a lane-valid mask and an end-of-packet flag.
- Drives FIFO winc/wdata and observes wfull, so no data is lost or duplicated under backpressure.
- Counts packets committed to the FIFO.

Parameters:
IN_W, 8, input beat data width in bits
RATIO, 4, input beats per FIFO word; power of two, >= 2
DSIZE, RATIO*IN_W+RATIO+1, FIFO word width; derived, must not be overridden
CNT_W, 16, packet counter width

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  reset, asynchronous, active-low
s_axis_tdata  input  IN_W  input beat data
s_axis_tvalid  input  1  input beat valid
s_axis_tlast  input  1  last beat of packet
s_axis_tready  output  1  input beat accepted when tvalid&&tready
fifo_wdata  output  DSIZE  word to FIFO write port
fifo_winc  output  1  FIFO write request
fifo_wfull  input  1  FIFO full; the FIFO ignores winc while high
pkt_cnt  output  CNT_W  packets whose last word has been written to the FIFO; wraps

Behaviour:
- Word layout:
  - bit DSIZE-1 = last
  - bits [DSIZE-2 : RATIO*IN_W] = lane mask; bit i set = lane i valid
  - bits [RATIO*IN_W-1:0] = data; lane i at [i*IN_W +: IN_W]
  - lane 0 holds the first beat; unfilled lanes are zero
- State:
  - accumulator: data, mask, lane_idx of $clog2(RATIO) bits
  - output register: out_word, out_vld
- Outputs:
  - fifo_winc = out_vld
  - fifo_wdata = out_word
  - drain = out_vld && !fifo_wfull
- s_axis_tready = !out_vld || !fifo_wfull
  - combinational from state and wfull only; never depends on tvalid
- Beat accept (tvalid && tready):
  - write the beat into lane lane_idx and set that mask bit
  - complete = (lane_idx == RATIO-1) || tlast
  - if complete: next edge loads out_word from {tlast, mask, data} including the current beat, sets out_vld, and clears the accumulator (data 0, mask 0, lane_idx 0)
  - else: lane_idx increments
- Output register:
  - if drain and no new complete word: out_vld clears
  - if drain and complete in the same cycle: out_word is replaced and out_vld stays 1 (back-to-back words, no bubble)
  - if out_vld && fifo_wfull: out_word holds stable; tready = 0
- Latency: the beat completing a word at edge N makes fifo_winc = 1 in cycle N+1; it is written at edge N+1 if wfull = 0.
- Throughput: one beat per cycle while the FIFO is not full.
- tlast on lane 0 gives a word with mask = 0001 and last = 1.
- There is no timeout flush: a partial word without tlast stays in the accumulator indefinitely.
- pkt_cnt increments by 1 on each drain with out_word[DSIZE-1] = 1; wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous assert):
  - accumulator = 0, lane_idx = 0, out_vld = 0, out_word = 0, pkt_cnt = 0
  - hence fifo_winc = 0, fifo_wdata = 0, s_axis_tready = 1
- Reset mid-packet or mid-word:
  - partial accumulator and any pending out_word are discarded
  - no FIFO write occurs for them; pkt_cnt restarts at 0
- A beat presented while tready = 0 is not consumed; tdata/tlast are sampled only on handshake.

Decomposition:
- Shared package axis_fifo_pkg holds the word-layout constants as functions of IN_W/RATIO:
  - LAST_BIT
  - MASK_LSB, MASK_MSB
  - DATA_MSB
  - derived DSIZE
- The FIFO instance and the read-side unpacker use the same constants.
- Single module; no sub-module is needed.

Test Plan:
- After reset, 4 beats 0x11,0x22,0x33,0x44 with tlast on the 4th, wfull = 0 -> one write, fifo_wdata = {1, 4'b1111, 32'h44332211}; pkt_cnt = 1.
- 6-beat packet 0x01..0x06, tlast on 0x06 -> words {0, 1111, 32'h04030201} then {1, 0011, 32'h00000605}; pkt_cnt increments once, at the second write.
- Hold fifo_wfull = 1 with a word pending, continue streaming -> tready = 0 after the next completed word would need the slot; fifo_wdata stable; after wfull drops every word is written exactly once and in order.
- Continuous tvalid, wfull = 0, 16 beats without tlast -> 4 writes on consecutive word boundaries with no idle cycle; tready is never 0.
- Assert wrst_n = 0 after 2 beats of a word -> no FIFO write; after release the next 4-beat packet produces a word with mask 1111 and only the new data.
- Single-beat packet 0xAB with tlast -> {1, 0001, 32'h000000AB}; pkt_cnt wrap check: preload to 0xFFFF via 65535 single-beat packets (or force) -> next packet gives 0x0000.
